// File: rtl/dp_ram_fifo_ctrl_if.sv
// Push/pop valid-ready handshake bundle for dp_ram_fifo_ctrl.
// The master side is the producer/consumer; the slave side is the FIFO.
interface dp_ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller in front of a true dual-port RAM: port A write-only,
// port B read-only with 1-cycle registered read data. A 2-entry output
// stage (out register + skid register) hides the read latency so the
// FIFO sustains one word per cycle in first-word-fall-through style.
// Optional high-water-mark tracking is enabled by defining DP_FIFO_CTRL_HWM_EN.
module dp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  dp_ram_fifo_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic                  ram_enb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
`ifdef DP_FIFO_CTRL_HWM_EN
  ,
  output logic [ADDR_WIDTH+1:0] hwm,
  input  logic                  hwm_clr
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
  logic                  rd_pend_q;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  logic       push_fire;
  logic       pop_fire;
  logic       issue;
  logic [1:0] staged;
  logic [1:0] staged_after_pop;
  logic [1:0] staged_d;
  logic [ADDR_WIDTH+1:0] count_d;

  // Handshake and read-issue decisions; RAM strobes are suppressed in reset.
  always_comb begin
    staged           = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q);
    push_fire        = bus.in_valid && bus.in_ready && !rst;
    pop_fire         = out_valid_q && bus.out_ready;
    // pop_fire implies out_valid_q, so this never underflows
    staged_after_pop = staged - 2'(pop_fire);
    issue            = (mem_cnt_q != '0) && (staged_after_pop < 2'd2) && !rst;
    wr_ptr_d         = wr_ptr_q + ADDR_WIDTH'(push_fire);
    rd_ptr_d         = rd_ptr_q + ADDR_WIDTH'(issue);
    mem_cnt_d        = mem_cnt_q + (ADDR_WIDTH+1)'(push_fire) - (ADDR_WIDTH+1)'(issue);
  end

  // Output stage steering: returning RAM word goes to out if it is free or
  // being vacated, else to skid; a pop with skid full promotes skid to out.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop_fire) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = rd_pend_q;
        if (rd_pend_q) begin
          skid_data_d = ram_doutb;
        end
      end else if (rd_pend_q) begin
        out_data_d = ram_doutb;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_doutb;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = ram_doutb;
      end
    end
    staged_d = 2'(out_valid_d) + 2'(skid_valid_d) + 2'(issue);
    count_d  = (ADDR_WIDTH+2)'(mem_cnt_d) + (ADDR_WIDTH+2)'(staged_d);
  end

  // State registers; reset drops any read in flight and empties the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      rd_pend_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      rd_pend_q    <= issue;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef DP_FIFO_CTRL_HWM_EN
  logic [ADDR_WIDTH+1:0] hwm_q;

  // High-water mark of total occupancy; clear reloads the current level.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (hwm_clr) begin
      hwm_q <= count_d;
    end else if (count_d > hwm_q) begin
      hwm_q <= count_d;
    end
  end

  assign hwm = hwm_q;
`else
  // Next-state occupancy is only consumed by the high-water-mark logic.
  logic unused_count_d;
  assign unused_count_d = ^count_d;
`endif

  assign bus.in_ready  = (mem_cnt_q != DEPTH_C);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign count         = (ADDR_WIDTH+2)'(mem_cnt_q) + (ADDR_WIDTH+2)'(staged);

  assign ram_ena   = push_fire;
  assign ram_wea   = push_fire;
  assign ram_addra = wr_ptr_q;
  assign ram_dina  = bus.in_data;
  assign ram_enb   = issue;
  assign ram_web   = 1'b0;
  assign ram_addrb = rd_ptr_q;

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Directed/table-driven bench for dp_ram_fifo_ctrl with a behavioural
// dual-port RAM. Build with DP_FIFO_CTRL_HWM_EN to exercise the hwm port.
module tb_dp_ram_fifo_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dp_ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  logic [AW+1:0] count;
  logic          ram_ena, ram_wea, ram_enb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;
`ifdef DP_FIFO_CTRL_HWM_EN
  logic [AW+1:0] hwm;
  logic          hwm_clr;
`endif

  dp_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .count     (count),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_enb   (ram_enb),
    .ram_web   (ram_web),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
`ifdef DP_FIFO_CTRL_HWM_EN
    ,
    .hwm       (hwm),
    .hwm_clr   (hwm_clr)
`endif
  );

  // Behavioural true dual-port RAM with registered port-B read data.
  logic [DW-1:0] ram_mem [1<<AW];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= ram_mem[ram_addrb];
  end

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] sb [$];
  logic          prev_stall;
  logic [DW-1:0] prev_od;

  logic          s_irdy, s_ov, s_enb, s_push, s_pop;
  logic [DW-1:0] s_od;
  logic [AW+1:0] s_cnt;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_irdy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [AW+1:0] e_cnt;
    logic          e_enb;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/empty expected event", name);
  endtask

  // One clock cycle: drive, sample at negedge, scoreboard, advance past posedge.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(negedge clk);
    s_irdy = bus.in_ready;
    s_ov   = bus.out_valid;
    s_od   = bus.out_data;
    s_cnt  = count;
    s_enb  = ram_enb;
    s_push = iv && s_irdy;
    s_pop  = s_ov && ordy;
    if (prev_stall) chk("hold", 64'({s_ov, s_od}), 64'({1'b1, prev_od}));
    prev_stall = s_ov && !ordy;
    prev_od    = s_od;
    if (s_push) sb.push_back(d);
    if (s_pop) begin
      if (sb.size() == 0) fail_now("pop_unexpected");
      else chk("order", 64'(s_od), 64'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst        = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int c = 0; c < maxc && sb.size() != 0; c++) step(1'b0, '0, 1'b1);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int k, rcv, first, last, c;
    logic found;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    prev_stall    = 1'b0;
    prev_od       = '0;
`ifdef DP_FIFO_CTRL_HWM_EN
    hwm_clr = 1'b0;
`endif

    //          iv    d        ordy  irdy  ov    od       cnt   enb
    vt[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h0,  6'd0, 1'b0};
    vt[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 32'h0,  6'd1, 1'b1};
    vt[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 32'h0,  6'd2, 1'b1};
    vt[3] = '{1'b1, 32'hA3, 1'b0, 1'b1, 1'b1, 32'hA0, 6'd3, 1'b0};
    vt[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA0, 6'd4, 1'b0};
    vt[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA0, 6'd4, 1'b1};
    vt[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA1, 6'd3, 1'b1};
    vt[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA2, 6'd2, 1'b0};
    vt[8] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'hA3, 6'd1, 1'b0};
    vt[9] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  6'd0, 1'b0};

    // Latency / staging sequence from reset
    do_reset();
    chk("reset_state", 64'({bus.in_ready, bus.out_valid, count}), 64'({1'b1, 1'b0, 6'd0}));
    for (int i = 0; i < 10; i++) begin
      step(vt[i].iv, vt[i].d, vt[i].ordy);
      chk($sformatf("vec%0d", i),
          64'({s_irdy, s_ov, (vt[i].e_ov ? s_od : 32'h0), s_cnt, s_enb}),
          64'({vt[i].e_irdy, vt[i].e_ov, vt[i].e_od, vt[i].e_cnt, vt[i].e_enb}));
      $display("vec%0d iv=%0b d=%0h ordy=%0b -> irdy=%0b ov=%0b od=%0h cnt=%0d enb=%0b",
               i, vt[i].iv, vt[i].d, vt[i].ordy, s_irdy, s_ov, s_od, s_cnt, s_enb);
    end
    chk("ram_web", 64'(ram_web), 64'd0);

    // Streaming 200 words, wrapping the 16-entry RAM many times
    do_reset();
    k = 0; rcv = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 400 && rcv < 200; cyc++) begin
      step(k < 200, DW'(k), 1'b1);
      if (s_push) k++;
      if (s_pop) begin
        if (first < 0) first = cyc;
        last = cyc;
        rcv++;
      end
    end
    chk("stream_rcv", 64'(rcv), 64'd200);
    chk("stream_first_cycle", 64'(first), 64'd3);
    chk("stream_throughput", 64'(last - first), 64'd199);
    $display("stream: received %0d words, first at cycle %0d, last at %0d", rcv, first, last);

    // Fill to full with no pops, then a single pop re-opens in_ready
    do_reset();
    k = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step(1'b1, DW'(32'h100 + k), 1'b0);
      if (s_push) k++;
      else break;
    end
    chk("fill_words", 64'(k), 64'd18);
    chk("fill_count", 64'({s_irdy, s_cnt}), 64'({1'b0, 6'd18}));
    step(1'b0, '0, 1'b1);
    chk("full_pop_issue", 64'({s_pop, s_enb, s_irdy}), 64'({1'b1, 1'b1, 1'b0}));
    step(1'b0, '0, 1'b0);
    chk("full_reopen", 64'({s_irdy, s_cnt}), 64'({1'b1, 6'd17}));
    drain(60);
    $display("fill: %0d words held at full, drained in order", k);

    // Random producer stalls and consumer backpressure
    do_reset();
    k = 0; rcv = 0;
    for (int cyc = 0; cyc < 8000 && rcv < 1000; cyc++) begin
      step((k < 1000) && ($urandom_range(0, 99) < 70), DW'($urandom), 1'($urandom_range(0, 1)));
      if (s_push) k++;
      if (s_pop) rcv++;
    end
    chk("random_rcv", 64'(rcv), 64'd1000);
    chk("random_sb_empty", 64'(sb.size()), 64'd0);
    $display("random: pushed %0d popped %0d", k, rcv);

    // Reset while a read is in flight and out holds a word
    do_reset();
    step(1'b1, 32'hB0, 1'b0);
    step(1'b1, 32'hB1, 1'b0);
    step(1'b1, 32'hB2, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h77;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    chk("rst_pre_ov", 64'(bus.out_valid), 64'd1);
    chk("rst_ram_strobes", 64'({ram_ena, ram_wea, ram_enb}), 64'd0);
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    prev_stall   = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("rst_post", 64'({s_irdy, s_ov, s_cnt, s_enb}), 64'({1'b1, 1'b0, 6'd0, 1'b0}));
    step(1'b1, 32'h55, 1'b0);
    found = 1'b0;
    c = 0;
    while (c < 10 && !found) begin
      step(1'b0, '0, 1'b1);
      if (s_pop) begin
        found = 1'b1;
        chk("first_after_rst", 64'(s_od), 64'h55);
      end
      c++;
    end
    if (!found) fail_now("first_after_rst_timeout");
    $display("mid-op reset: first word after reset popped=%0b", found);

`ifdef DP_FIFO_CTRL_HWM_EN
    // High-water mark: fill to 10, drain, then clear
    do_reset();
    step(1'b0, '0, 1'b0);
    chk("hwm_reset", 64'(hwm), 64'd0);
    for (int i = 0; i < 10; i++) step(1'b1, DW'(32'hC0 + i), 1'b0);
    drain(40);
    step(1'b0, '0, 1'b0);
    chk("hwm_peak", 64'({hwm, s_cnt}), 64'({6'd10, 6'd0}));
    hwm_clr = 1'b1;
    step(1'b0, '0, 1'b0);
    hwm_clr = 1'b0;
    step(1'b0, '0, 1'b0);
    chk("hwm_clr", 64'(hwm), 64'd0);
    $display("hwm: peak/clear sequence done, hwm=%0d", hwm);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dp_ram_fifo_ctrl.md
Name: dp_ram_fifo_ctrl

Overview:
Single-clock FIFO controller placed directly in front of the team's true dual-port RAM.
- Port A of the RAM is driven write-only; push data goes in through it.
- Port B is driven read-only; this block consumes the RAM's registered port-B read data.
- Presents valid/ready push and pop interfaces, first-word-fall-through style, with a 2-entry output stage that hides the 1-cycle RAM read latency and sustains 1 word/cycle.

Parameters:
DATA_WIDTH, 32, word width; must match the RAM.
ADDR_WIDTH, 10, RAM address width; RAM depth DEPTH = 1<<ADDR_WIDTH.

Ports:
clk  input  1  single clock; both RAM clocks (clka, clkb) are tied to it.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  push request.
in_ready  output  1  high when a push is accepted.
in_data  input  DATA_WIDTH  push data.
out_valid  output  1  out_data holds the oldest word.
out_ready  input  1  pop request.
out_data  output  DATA_WIDTH  head-of-FIFO word.
count  output  ADDR_WIDTH+2  total words held (RAM + staged + in flight).
ram_ena  output  1  RAM port A enable; equals push fire.
ram_wea  output  1  RAM port A write enable; equals push fire.
ram_addra  output  ADDR_WIDTH  write pointer.
ram_dina  output  DATA_WIDTH  equals in_data.
ram_enb  output  1  RAM port B enable; equals read-issue.
ram_web  output  1  constant 0.
ram_addrb  output  ADDR_WIDTH  read pointer.
ram_doutb  input  DATA_WIDTH  RAM port B read data; valid the cycle after ram_enb; held while ram_enb is low.

Behaviour:
- Push fire: in_valid && in_ready.
- Pop fire: out_valid && out_ready.
- mem_cnt: words resident in RAM and not yet read. Range 0..DEPTH, width ADDR_WIDTH+1.
- in_ready = (mem_cnt != DEPTH). It does not look ahead at a same-cycle read-issue.
- Write path:
  - On push fire: ram_ena = ram_wea = 1, ram_addra = wr_ptr.
  - wr_ptr increments modulo DEPTH (natural wrap).
- staged = out_valid + skid_valid + rd_pend (0..2).
- Read issue: issue = (mem_cnt != 0) && (staged - pop_fire < 2).
  - On issue: ram_enb = 1, ram_addrb = rd_ptr; rd_ptr increments modulo DEPTH; rd_pend <= 1 for the next cycle.
- A word written at edge t can be read-issued no earlier than cycle t+1. Port A and port B therefore never access the same address in the same cycle.
- Data capture: in the cycle where rd_pend = 1, ram_doutb is loaded into the output register.
  - If the output register is empty, or is being popped this cycle, load it directly.
  - Otherwise load the skid register.
  - A pop while skid_valid = 1 moves skid into out; the arriving word then goes to skid.
- Order is strictly FIFO. out_data and out_valid are held stable while out_valid && !out_ready.
- Latency: push at cycle t gives earliest out_valid at cycle t+3. Throughput is 1 word/cycle with both sides streaming.
- mem_cnt next = mem_cnt + push_fire - issue. Simultaneous push and issue at mem_cnt = DEPTH cannot occur, because in_ready = 0 there.
- count = mem_cnt + staged. Maximum value DEPTH+2.
- Reset (also mid-operation):
  - wr_ptr, rd_ptr, mem_cnt, rd_pend, skid_valid, out_valid all go to 0.
  - out_data goes to 0; count goes to 0.
  - ram_ena, ram_wea and ram_enb are 0 during reset.
  - A read in flight at reset is discarded.
  - RAM contents are not cleared.
  - in_ready is 1 in the first cycle after reset deasserts.
- ram_web is always 0. Port A read data is unused.

Optional Feature:
Macro DP_FIFO_CTRL_HWM_EN.
- Defined:
  - Adds output port hwm (ADDR_WIDTH+2) and input port hwm_clr (1).
  - hwm <= max(hwm, count_next) every cycle.
  - hwm_clr loads count_next, and takes priority over the max update.
  - Reset sets hwm to 0.
- Not defined: neither port exists, and no logic is added.

Test Plan:
1. Reset, then push 0xA0..0xA3 on consecutive cycles with out_ready = 0 → 0xA0 appears at out_valid 3 cycles after its push; count reaches 4; mem_cnt reaches 2 (2 words staged).
2. Streaming with ADDR_WIDTH = 4: 200 words with in_valid = out_ready = 1 → output order matches input order, one word/cycle after the initial 3-cycle latency, and pointers wrap past 15 correctly.
3. Fill with out_ready = 0 → in_ready drops when mem_cnt = 16 and count = 18; one pop then raises in_ready the cycle after the resulting read-issue.
4. Random out_ready backpressure (50%) with a randomly stalling producer → no loss or duplication; out_data stable while stalled; a scoreboard matches 1000 words.
5. Assert rst while rd_pend = 1 and out_valid = 1 → next cycle out_valid = 0, count = 0, in_ready = 1, no ram_enb pulse; a new push of 0x55 emerges as the first output.
6. DP_FIFO_CTRL_HWM_EN: fill to 10 words, drain to 0 → hwm = 10; pulse hwm_clr → hwm = 0.
